// File: rtl/servo_pkg.sv
// Shared definitions for the servo PWM path (Avalon slave and PWM core).
//   servo_pwm_state_t    : frame generator state (IDLE / HIGH / LOW)
//   SERVO_PERIOD_CYCLES  : default frame length, 20 ms at 50 MHz
//   SERVO_MIN_PULSE      : default lower clamp bound, 1 ms
//   SERVO_MAX_PULSE      : default upper clamp bound, 2 ms
//   servo_cnt_width()    : bits needed to count 0..period
package servo_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } servo_pwm_state_t;

    localparam int unsigned SERVO_PERIOD_CYCLES = 1000000;
    localparam int unsigned SERVO_MIN_PULSE     = 50000;
    localparam int unsigned SERVO_MAX_PULSE     = 100000;

    // Width of a counter that must hold values 0..period inclusive.
    function automatic int unsigned servo_cnt_width(input int unsigned period);
        int unsigned w;
        w = 32'($clog2(64'(period) + 64'd1));
        if (w < 1) begin
            w = 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/servo_pwm_core.sv
// Servo PWM frame generator with a one-entry shadow register.
// Each accepted pulse_time produces one frame of PERIOD_CYCLES clocks, high for
// the effective width and low for the remainder. A value loaded mid-frame is
// held in the shadow register and starts the next frame with no idle gap.
//
// Ports:
//   clk          : system clock
//   reset_n      : asynchronous active-low reset
//   load         : one-cycle strobe, pulse_time valid in that cycle
//   pulse_time   : requested high time in clk cycles (WIDTH bits)
//   pwm_out      : servo PWM output (registered)
//   pwm_response : 1 = idle with nothing pending (registered)
//
// Build option: define SERVO_PWM_CLAMP_EN to clamp nonzero widths into
// [MIN_PULSE, MAX_PULSE]; otherwise widths saturate at PERIOD_CYCLES.
module servo_pwm_core
    import servo_pkg::*;
#(
    parameter int unsigned WIDTH         = 32,
    parameter int unsigned PERIOD_CYCLES = SERVO_PERIOD_CYCLES,
    parameter int unsigned MIN_PULSE     = SERVO_MIN_PULSE,
    parameter int unsigned MAX_PULSE     = SERVO_MAX_PULSE
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic [WIDTH-1:0] pulse_time,
    output logic             pwm_out,
    output logic             pwm_response
);

    localparam int unsigned CW = servo_cnt_width(PERIOD_CYCLES);
    // Compare width wide enough for both pulse_time and the 32-bit parameters.
    localparam int unsigned EW = (WIDTH > 32) ? WIDTH : 32;
    localparam logic [CW-1:0] LAST_CNT = CW'(PERIOD_CYCLES - 1);

    // Saturate the request at one full frame.
    function automatic logic [CW-1:0] sat_pulse(input logic [WIDTH-1:0] v);
        logic [CW-1:0] r;
        if (EW'(v) >= EW'(PERIOD_CYCLES)) begin
            r = CW'(PERIOD_CYCLES);
        end else begin
            r = CW'(v);
        end
        return r;
    endfunction

    // Zero stays zero (relax frame); anything else is held inside the servo range.
    function automatic logic [CW-1:0] clamp_pulse(input logic [WIDTH-1:0] v);
        logic [CW-1:0] r;
        if (EW'(v) == EW'(0)) begin
            r = '0;
        end else if (EW'(v) < EW'(MIN_PULSE)) begin
            r = CW'(MIN_PULSE);
        end else if (EW'(v) > EW'(MAX_PULSE)) begin
            r = CW'(MAX_PULSE);
        end else begin
            r = CW'(v);
        end
        return r;
    endfunction

    function automatic logic [CW-1:0] eff_pulse(input logic [WIDTH-1:0] v);
`ifdef SERVO_PWM_CLAMP_EN
        return clamp_pulse(v);
`else
        return sat_pulse(v);
`endif
    endfunction

    servo_pwm_state_t state, state_n;
    logic [CW-1:0]    cnt, cnt_n;
    logic [CW-1:0]    pulse, pulse_n;
    logic             pend_valid, pend_valid_n;
    logic [CW-1:0]    pend_val, pend_val_n;
    logic             start;
    logic [CW-1:0]    start_val;

    // State, counter, shadow register and registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            cnt          <= '0;
            pulse        <= '0;
            pend_valid   <= 1'b0;
            pend_val     <= '0;
            pwm_out      <= 1'b0;
            pwm_response <= 1'b1;
        end else begin
            state        <= state_n;
            cnt          <= cnt_n;
            pulse        <= pulse_n;
            pend_valid   <= pend_valid_n;
            pend_val     <= pend_val_n;
            pwm_out      <= (state_n == HIGH);
            pwm_response <= (state_n == IDLE) && !pend_valid_n;
        end
    end

    // Next-state: cnt is the index of the current cycle within the frame.
    always_comb begin
        state_n      = state;
        cnt_n        = cnt;
        pulse_n      = pulse;
        pend_valid_n = pend_valid;
        pend_val_n   = pend_val;
        start        = 1'b0;
        start_val    = '0;

        case (state)
            IDLE: begin
                if (load) begin
                    start     = 1'b1;
                    start_val = eff_pulse(pulse_time);
                end
            end
            HIGH, LOW: begin
                if (cnt == LAST_CNT) begin
                    // Final frame cycle: a same-cycle load beats the shadow value.
                    pend_valid_n = 1'b0;
                    if (load) begin
                        start     = 1'b1;
                        start_val = eff_pulse(pulse_time);
                    end else if (pend_valid) begin
                        start     = 1'b1;
                        start_val = pend_val;
                    end else begin
                        state_n = IDLE;
                        cnt_n   = '0;
                    end
                end else begin
                    cnt_n = cnt + CW'(1);
                    if ((state == HIGH) && (cnt + CW'(1) == pulse)) begin
                        state_n = LOW;
                    end
                    if (load) begin
                        pend_valid_n = 1'b1;
                        pend_val_n   = eff_pulse(pulse_time);
                    end
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        if (start) begin
            cnt_n   = '0;
            pulse_n = start_val;
            state_n = (start_val == '0) ? LOW : HIGH;
        end
    end

endmodule

// File: doc/servo_pwm_core.md
Name: servo_pwm_core

Overview:
Downstream stage of the servo Avalon slave. It takes a pulse-width value and a one-cycle load strobe from the slave. It generates one fixed-period servo PWM frame per accepted value on pwm_out, and drives pwm_response back to the slave as its ready/idle indication. A one-entry shadow register allows back-to-back frames with no gap.

Parameters:
WIDTH, 32, width of pulse_time in bits
PERIOD_CYCLES, 1000000, frame length in clk cycles (20 ms at 50 MHz); must be >= 2
MIN_PULSE, 50000, lower clamp bound in cycles (1 ms); used only with the clamp feature
MAX_PULSE, 100000, upper clamp bound in cycles (2 ms); require MIN_PULSE <= MAX_PULSE <= PERIOD_CYCLES

Ports:
clk  in  1  system clock; the single clock for the block
reset_n  in  1  asynchronous, active-low reset
load  in  1  one-cycle strobe from the slave; pulse_time is valid in that cycle
pulse_time  in  WIDTH  requested high time, in clk cycles
pwm_out  out  1  servo PWM output, registered
pwm_response  out  1  1 = idle with nothing pending; 0 = frame active or value pending; registered

Behaviour:
- Reset (async, immediate on reset_n low):
  - pwm_out=0, pwm_response=1, state=IDLE.
  - Counter=0, pending_valid=0, pending value=0.
- FSM states: IDLE, HIGH, LOW.
- Effective width P_eff = min(pulse_time, PERIOD_CYCLES), computed in WIDTH bits with no truncation before the compare. The counter is clog2(PERIOD_CYCLES+1) bits wide.
- IDLE + load:
  - In the next cycle pwm_out=1 and pwm_response=0 (latency 1).
  - State goes to HIGH, or directly to LOW if P_eff=0.
- Frame timing:
  - pwm_out is high for exactly P_eff cycles, then low for PERIOD_CYCLES-P_eff cycles.
  - Total frame length is exactly PERIOD_CYCLES cycles.
  - If P_eff=PERIOD_CYCLES, the LOW phase is skipped.
- load while HIGH or LOW:
  - The value is written to the shadow register and pending_valid=1.
  - Repeated loads overwrite it (last write wins).
  - The active frame is never altered.
- End of frame (last cycle of the frame):
  - If pending_valid=1 or load=1 in that cycle, the next frame starts in the following cycle with no idle gap. A same-cycle load takes priority over the shadow value. pending_valid clears.
  - Otherwise state returns to IDLE, and pwm_response=1 in the following cycle.
- pwm_response is registered: it equals (next_state==IDLE && !next_pending_valid).
- load while reset_n is low is ignored.
- Reset asserted mid-frame: pwm_out drops to 0 immediately and the pending value is discarded.

Optional Feature:
SERVO_PWM_CLAMP_EN
- Defined:
  - Nonzero pulse_time is clamped: P_eff = max(MIN_PULSE, min(pulse_time, MAX_PULSE)).
  - pulse_time=0 still gives P_eff=0, an all-low "relax" frame.
  - The clamp is applied at the moment the value is accepted (load or shadow write).
- Undefined: P_eff = min(pulse_time, PERIOD_CYCLES); MIN_PULSE and MAX_PULSE are unused.

Decomposition:
- Package servo_pkg holds:
  - the state enum typedef servo_pwm_state_t (IDLE/HIGH/LOW);
  - default constants SERVO_PERIOD_CYCLES, SERVO_MIN_PULSE and SERVO_MAX_PULSE, shared with the Avalon slave;
  - a function computing counter width.
- Single module, no sub-module. The clamp is a local function inside the module.

Test Plan (PERIOD_CYCLES=20, MIN_PULSE=2, MAX_PULSE=6):
1. Reset:
   - Hold reset_n=0 for 5 cycles, then release with load=0 -> pwm_out=0, pwm_response=1 throughout, no activity for 40 cycles.
   - Additionally, force pwm_out high mid-frame, then drop reset_n between clock edges -> pwm_out=0 before the next edge.
2. Single frame:
   - Stimulus: load with pulse_time=3 at cycle 0.
   - pwm_out=1 for cycles 1-3 and 0 for cycles 4-20.
   - pwm_response=0 for cycles 1-20 and returns to 1 at cycle 21.
3. Shadow register, last write wins:
   - Stimulus: load 4 at cycle 0, load 5 at cycle 7, load 6 at cycle 9.
   - First frame: high for cycles 1-4.
   - Second frame: high for cycles 21-26, low for 27-40.
   - pwm_response=0 for cycles 1-40 and returns to 1 at cycle 41.
4. Edge widths (clamp undefined):
   - pulse_time=0 -> 20 cycles low, pwm_response low for 20 cycles.
   - pulse_time=25 -> 20 cycles high, then IDLE.
   - With SERVO_PWM_CLAMP_EN defined: 25 -> 6 high; 1 -> 2 high; 0 -> all low.
5. Load on the final frame cycle:
   - Stimulus: load 3 at cycle 0, then load 2 at cycle 20.
   - Second frame is high for cycles 21-22 with no IDLE cycle between frames.
   - pwm_response stays 0 through cycle 40.
6. Reset mid-operation:
   - Stimulus: load 5, load 4 pending, then reset_n=0 at cycle 3.
   - pwm_out drops to 0 immediately and pwm_response goes to 1.
   - After release: no frame starts, because the pending value was discarded.
